// File: rtl/mips_pkg.sv
// Shared definitions for the ID/EX pipeline slice.
// Holds default datapath widths, control-bundle bit positions and the
// EX operand-forwarding select encoding.
package mips_pkg;

  localparam int DATA_W      = 32;
  localparam int REG_AW      = 5;
  localparam int CTRL_W      = 12;
  localparam int STALL_CNT_W = 16;

  // Control bundle bit positions
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_ALU_OP_LO  = 6;
  localparam int CTRL_ALU_OP_HI  = 9;
  localparam int CTRL_BRANCH     = 10;
  localparam int CTRL_SPARE      = 11;

  // EX operand select
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,  // value latched in ID/EX
    FWD_WB   = 2'b01,  // MEM/WB write data
    FWD_MEM  = 2'b10   // EX/MEM ALU result
  } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard / forwarding compare logic for the ID stage.
// Ports:
//   id_*            decoded ID instruction (indices, source-use flags, RF data)
//   ex_*            state of the instruction currently in ID/EX
//   mem_*           EX/MEM destination info
//   wb_*            MEM/WB write port
//   hz_o            load-use hazard against the instruction in EX
//   op_a_o/op_b_o   RF read data with same-cycle WB bypass applied
//   fwd_a_o/fwd_b_o next-cycle EX operand selects
// Register 0 is hard-wired zero, so it never matches anything here.
module hazard_fwd_unit #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic                 id_valid_i,
  input  logic [REG_AW-1:0]    id_rs_i,
  input  logic [REG_AW-1:0]    id_rt_i,
  input  logic                 id_use_rs_i,
  input  logic                 id_use_rt_i,
  input  logic [DATA_W-1:0]    id_rd1_i,
  input  logic [DATA_W-1:0]    id_rd2_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_mem_read_i,
  input  logic                 ex_reg_write_i,
  input  logic [REG_AW-1:0]    ex_rt_i,
  input  logic [REG_AW-1:0]    ex_dst_i,
  input  logic                 mem_regwrite_i,
  input  logic [REG_AW-1:0]    mem_rd_i,
  input  logic                 wb_regwrite_i,
  input  logic [REG_AW-1:0]    wb_rd_i,
  input  logic [DATA_W-1:0]    wb_data_i,
  output logic                 hz_o,
  output logic [DATA_W-1:0]    op_a_o,
  output logic [DATA_W-1:0]    op_b_o,
  output mips_pkg::fwd_sel_e   fwd_a_o,
  output mips_pkg::fwd_sel_e   fwd_b_o
);
  import mips_pkg::*;

  function automatic logic nz_eq(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // EX/MEM result is younger than MEM/WB data, so it wins.
  function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] src);
    if (ex_valid_i && ex_reg_write_i && nz_eq(ex_dst_i, src)) return FWD_MEM;
    if (mem_regwrite_i && nz_eq(mem_rd_i, src))               return FWD_WB;
    return FWD_NONE;
  endfunction

  logic rs_dep, rt_dep;
  assign rs_dep = id_use_rs_i && nz_eq(ex_rt_i, id_rs_i);
  assign rt_dep = id_use_rt_i && nz_eq(ex_rt_i, id_rt_i);
  assign hz_o   = id_valid_i && ex_valid_i && ex_mem_read_i && (rs_dep || rt_dep);

  // The register file writes on the same edge ID reads it, so pick up WB data here.
  assign op_a_o = (wb_regwrite_i && nz_eq(wb_rd_i, id_rs_i)) ? wb_data_i : id_rd1_i;
  assign op_b_o = (wb_regwrite_i && nz_eq(wb_rd_i, id_rt_i)) ? wb_data_i : id_rd2_i;

  assign fwd_a_o = fwd_sel(id_rs_i);
  assign fwd_b_o = fwd_sel(id_rt_i);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, ID-side WB bypass
// and EX forwarding-select precompute.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   id_*                decoded instruction from IF/ID
//   flush               redirect: kill the ID instruction
//   mem_*/wb_*          downstream destination info (wb_* is also the RF write port)
//   stall               combinational: hold PC and IF/ID this cycle
//   ex_*                ID/EX register contents
//   ex_fwd_a/ex_fwd_b   EX operand selects (00 latched, 01 WB, 10 MEM)
//   stall_cnt           saturating count of load-use bubbles
// The register itself never holds: a stall loads a bubble while IF/ID holds,
// so the stalled instruction is simply reloaded on the next edge.
module id_ex_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW,
  parameter int CTRL_W = mips_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dst,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b,
  output logic [15:0]       stall_cnt
);
  import mips_pkg::*;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [REG_AW-1:0] rt_q, rt_d, dst_q, dst_d;
  fwd_sel_e          fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic              hz;
  logic [DATA_W-1:0] op_a, op_b;
  fwd_sel_e          fwd_a, fwd_b;

  hazard_fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_hfu (
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_use_rs_i    (id_use_rs),
    .id_use_rt_i    (id_use_rt),
    .id_rd1_i       (id_rd1),
    .id_rd2_i       (id_rd2),
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (ctrl_q[CTRL_MEM_READ]),
    .ex_reg_write_i (ctrl_q[CTRL_REG_WRITE]),
    .ex_rt_i        (rt_q),
    .ex_dst_i       (dst_q),
    .mem_regwrite_i (mem_regwrite),
    .mem_rd_i       (mem_rd),
    .wb_regwrite_i  (wb_regwrite),
    .wb_rd_i        (wb_rd),
    .wb_data_i      (wb_data),
    .hz_o           (hz),
    .op_a_o         (op_a),
    .op_b_o         (op_b),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b)
  );

  // A flush already kills the instruction, so no stall is needed or counted.
  assign stall = hz & ~flush;

  always_comb begin
    valid_d     = 1'b0;
    ctrl_d      = '0;
    a_d         = '0;
    b_d         = '0;
    imm_d       = '0;
    rt_d        = '0;
    dst_d       = '0;
    fwd_a_d     = FWD_NONE;
    fwd_b_d     = FWD_NONE;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (!(flush || stall)) begin
      valid_d = id_valid;
      ctrl_d  = id_valid ? id_ctrl : '0;
      a_d     = op_a;
      b_d     = op_b;
      imm_d   = id_imm;
      rt_d    = id_rt;
      dst_d   = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
      fwd_a_d = fwd_a;
      fwd_b_d = fwd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      rt_q        <= '0;
      dst_q       <= '0;
      fwd_a_q     <= FWD_NONE;
      fwd_b_q     <= FWD_NONE;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      rt_q        <= rt_d;
      dst_q       <= dst_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid  = valid_q;
  assign ex_ctrl   = ctrl_q;
  assign ex_a      = a_q;
  assign ex_b      = b_q;
  assign ex_imm    = imm_q;
  assign ex_rt     = rt_q;
  assign ex_dst    = dst_q;
  assign ex_fwd_a  = fwd_a_q;
  assign ex_fwd_b  = fwd_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam logic [11:0] C_LW  = 12'h01B; // reg_write|mem_read|mem_to_reg|alu_src
  localparam logic [11:0] C_ADD = 12'h0A1; // reg_write|reg_dst|alu_op=2

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs, id_use_rt, flush, mem_regwrite, wb_regwrite;
  logic [4:0]  id_rs, id_rt, id_rd, mem_rd, wb_rd;
  logic [31:0] id_rd1, id_rd2, id_imm, wb_data;
  logic [11:0] id_ctrl;
  logic        stall, ex_valid;
  logic [11:0] ex_ctrl;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rt, ex_dst;
  logic [1:0]  ex_fwd_a, ex_fwd_b;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  bit armed = 0;
  bit preload = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rt(ex_rt),
    .ex_dst(ex_dst), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // What the ID/EX register must hold, tracked from the architectural rules.
  logic        m_valid;
  logic [11:0] m_ctrl;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_rt, m_dst;
  logic [1:0]  m_fa, m_fb;
  logic [15:0] m_cnt;

  function automatic bit is_src(input logic [4:0] r);
    return r != 0 && ((id_use_rs && id_rs == r) || (id_use_rt && id_rt == r));
  endfunction

  // Load in EX whose result the ID instruction needs, not being flushed.
  function automatic bit want_stall();
    return !flush && id_valid && m_valid && m_ctrl[1] && is_src(m_rt);
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] r, input logic [31:0] raw);
    return (wb_regwrite && wb_rd != 0 && wb_rd == r) ? wb_data : raw;
  endfunction

  function automatic logic [1:0] src_sel(input logic [4:0] r);
    if (r == 0) return 2'd0;
    if (m_valid && m_ctrl[0] && m_dst == r) return 2'd2;
    if (mem_regwrite && mem_rd == r) return 2'd1;
    return 2'd0;
  endfunction

  always @(posedge clk) begin : model
    bit st;
    if (reset) begin
      m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_imm = 0;
      m_rt = 0; m_dst = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
    end else begin
      st = want_stall();
      if (flush || st) begin
        if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_imm = 0;
        m_rt = 0; m_dst = 0; m_fa = 0; m_fb = 0;
      end else begin
        // selects use the EX state before this edge, so compute them first
        m_fa    = src_sel(id_rs);
        m_fb    = src_sel(id_rt);
        m_valid = id_valid;
        m_ctrl  = id_valid ? id_ctrl : 12'h0;
        m_a     = rf_read(id_rs, id_rd1);
        m_b     = rf_read(id_rt, id_rd2);
        m_imm   = id_imm;
        m_rt    = id_rt;
        m_dst   = id_ctrl[5] ? id_rd : id_rt;
      end
    end
    if (preload) m_cnt = 16'hFFFE;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      chk("ex_ctrl", {20'd0, ex_ctrl}, {20'd0, m_ctrl});
      chk("ex_a", ex_a, m_a);
      chk("ex_b", ex_b, m_b);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_rt", {27'd0, ex_rt}, {27'd0, m_rt});
      chk("ex_dst", {27'd0, ex_dst}, {27'd0, m_dst});
      chk("ex_fwd_a", {30'd0, ex_fwd_a}, {30'd0, m_fa});
      chk("ex_fwd_b", {30'd0, ex_fwd_b}, {30'd0, m_fb});
      chk("stall", {31'd0, stall}, {31'd0, want_stall()});
      if (!preload) chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_cnt});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_use_rs = 0; id_use_rt = 0;
    id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_ctrl = 0; flush = 0;
    mem_regwrite = 0; mem_rd = 0; wb_regwrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urs, input logic urt, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] im, input logic [11:0] c);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_use_rs = urs; id_use_rt = urt;
    id_rd1 = d1; id_rd2 = d2; id_imm = im; id_ctrl = c;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    armed = 1;
    tick();
    chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
    reset = 0;

    // load-use: lw r8 in EX, add reading r8 in ID
    set_id(5'd1, 5'd8, 5'd0, 1, 0, 32'd100, 32'd0, 32'd4, C_LW);
    tick();
    chk("lw ex_dst", {27'd0, ex_dst}, 32'd8);
    chk("lw ex_a", ex_a, 32'd100);
    set_id(5'd8, 5'd2, 5'd10, 1, 1, 32'd7, 32'd3, 32'd0, C_ADD);
    #1 chk("lu stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lu bubble valid", {31'd0, ex_valid}, 32'd0);
    chk("lu stall_cnt", {16'd0, stall_cnt}, 32'd1);
    mem_regwrite = 1; mem_rd = 5'd8;
    #1 chk("post-bubble stall", {31'd0, stall}, 32'd0);
    tick();
    chk("held add fwd_a", {30'd0, ex_fwd_a}, 32'd1);
    chk("held add dst", {27'd0, ex_dst}, 32'd10);

    // EX forward beats MEM forward
    idle();
    set_id(5'd1, 5'd2, 5'd9, 1, 1, 32'd1, 32'd2, 32'd0, C_ADD);
    tick();
    set_id(5'd9, 5'd4, 5'd11, 1, 1, 32'd5, 32'd6, 32'd0, C_ADD);
    mem_regwrite = 1; mem_rd = 5'd9;
    tick();
    chk("ex fwd_a pri", {30'd0, ex_fwd_a}, 32'd2);
    chk("ex fwd_b none", {30'd0, ex_fwd_b}, 32'd0);

    // WB bypass, and register 0 never bypasses
    idle();
    set_id(5'd3, 5'd5, 5'd12, 1, 1, 32'd1, 32'd0, 32'd0, C_ADD);
    wb_regwrite = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    chk("wb bypass b", ex_b, 32'hDEADBEEF);
    chk("wb no bypass a", ex_a, 32'd1);
    id_rt = 5'd0; wb_rd = 5'd0;
    tick();
    chk("wb r0 b", ex_b, 32'd0);

    // flush coincident with a load-use hazard
    idle();
    set_id(5'd1, 5'd8, 5'd0, 1, 0, 32'd0, 32'd0, 32'd0, C_LW);
    tick();
    set_id(5'd8, 5'd2, 5'd10, 1, 1, 32'd7, 32'd3, 32'd0, C_ADD);
    flush = 1;
    #1 chk("flush stall", {31'd0, stall}, 32'd0);
    tick();
    chk("flush valid", {31'd0, ex_valid}, 32'd0);
    chk("flush ctrl", {20'd0, ex_ctrl}, 32'd0);
    chk("flush cnt", {16'd0, stall_cnt}, 32'd1);

    // load into r0 never stalls
    idle();
    set_id(5'd1, 5'd0, 5'd0, 1, 0, 32'd0, 32'd0, 32'd0, C_LW);
    tick();
    set_id(5'd0, 5'd0, 5'd3, 1, 1, 32'd0, 32'd0, 32'd0, C_ADD);
    #1 chk("r0 stall", {31'd0, stall}, 32'd0);
    tick();
    chk("r0 loads", {31'd0, ex_valid}, 32'd1);

    // invalid ID slot loads zero control
    idle();
    set_id(5'd1, 5'd2, 5'd3, 1, 1, 32'd9, 32'd9, 32'd9, C_ADD);
    id_valid = 0;
    tick();
    chk("inv ctrl", {20'd0, ex_ctrl}, 32'd0);

    // reset during a stall
    idle();
    set_id(5'd1, 5'd8, 5'd0, 1, 0, 32'd0, 32'd0, 32'd0, C_LW);
    tick();
    set_id(5'd8, 5'd2, 5'd10, 1, 1, 32'd7, 32'd3, 32'd0, C_ADD);
    #1 chk("pre-rst stall", {31'd0, stall}, 32'd1);
    reset = 1;
    tick();
    chk("rst valid", {31'd0, ex_valid}, 32'd0);
    chk("rst cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst a", ex_a, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    reset = 0;
    tick();
    chk("after rst load", {20'd0, ex_ctrl}, {20'd0, C_ADD});
    chk("after rst a", ex_a, 32'd7);

    // saturation from FFFE
    idle();
    preload = 1;
    force dut.stall_cnt_q = 16'hFFFE;
    tick();
    release dut.stall_cnt_q;
    preload = 0;
    chk("preload cnt", {16'd0, stall_cnt}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      set_id(5'd1, 5'd8, 5'd0, 1, 0, 32'd0, 32'd0, 32'd0, C_LW);
      tick();
      set_id(5'd8, 5'd2, 5'd10, 1, 1, 32'd7, 32'd3, 32'd0, C_ADD);
      tick();
    end
    chk("sat cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    idle();
    tick();
    chk("sat hold", {16'd0, stall_cnt}, 32'h0000FFFF);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width.
REQ-002 Parameter REG_AW, default 5, register index width.
REQ-003 Parameter CTRL_W, default 12, control bundle width; bit fields defined in the shared package.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-005 id_valid  in  1  IF/ID holds a real instruction.
REQ-006 id_rs, id_rt, id_rd  in  REG_AW  decoded register indices.
REQ-007 id_use_rs, id_use_rt  in  1  instruction reads rs / rt as a source.
REQ-008 id_rd1, id_rd2  in  DATA_W  register-file read data for rs / rt.
REQ-009 id_imm  in  DATA_W  sign-extended immediate.
REQ-010 id_ctrl  in  CTRL_W  decoded control (reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0], branch, spare).
REQ-011 flush  in  1  branch/jump redirect: kill the ID instruction.
REQ-012 mem_regwrite  in  1, mem_rd  in  REG_AW: EX/MEM destination info.
REQ-013 wb_regwrite  in  1, wb_rd  in  REG_AW, wb_data  in  DATA_W: MEM/WB write port, also driving register-file A3/WD3/WE3.
REQ-014 stall  out  1  combinational; hold PC and IF/ID this cycle.
REQ-015 ex_valid  out  1; ex_ctrl  out  CTRL_W; ex_a, ex_b, ex_imm  out  DATA_W; ex_rt, ex_dst  out  REG_AW.
REQ-016 ex_fwd_a, ex_fwd_b  out  2  EX operand select: 00 latched, 01 MEM/WB data, 10 EX/MEM result.
REQ-017 stall_cnt  out  16  saturating count of load-use bubbles.

Function
REQ-018 Hazard: hz = id_valid & ex_valid & ex_ctrl.mem_read & ex_rt!=0 & ((id_use_rs & ex_rt==id_rs) | (id_use_rt & ex_rt==id_rt)).
REQ-019 stall SHALL equal hz & ~flush.
REQ-020 ID-side WB bypass: operand A SHALL be wb_data when wb_regwrite & wb_rd!=0 & wb_rd==id_rs, else id_rd1; operand B likewise with id_rt/id_rd2.
REQ-021 ex_fwd_a next value SHALL be 10 if ex_valid & ex_ctrl.reg_write & ex_dst!=0 & ex_dst==id_rs; else 01 if mem_regwrite & mem_rd!=0 & mem_rd==id_rs; else 00; 10 wins over 01. ex_fwd_b is identical with id_rt.
REQ-022 Register 0 SHALL never match for bypass, forwarding or hazard.
REQ-023 ex_dst next value SHALL be id_rd if id_ctrl.reg_dst, else id_rt.
REQ-024 Each rising edge, priority: reset > flush > stall > load.
REQ-025 Flush or stall SHALL load a bubble: ex_valid=0, ex_ctrl=0, ex_fwd_a=ex_fwd_b=00; data fields don't-care but SHALL be zeroed.
REQ-026 Load SHALL capture the bypassed operands, id_imm, id_rt, ex_dst, fwd selects, id_ctrl, and ex_valid=id_valid; id_valid=0 SHALL load ctrl=0.
REQ-027 Latency: exactly one cycle from ID inputs to ex_* outputs; no internal hold, as the ID/EX register never stalls.
REQ-028 stall_cnt SHALL increment on every edge where stall=1 and saturate at 16'hFFFF.
REQ-029 Simultaneous flush and hazard: bubble inserted, stall=0, stall_cnt unchanged.

Reset
REQ-030 With reset high at an edge, all ex_* outputs, ex_fwd_a/b and stall_cnt SHALL become 0, overriding any flush or stall.
REQ-031 stall SHALL be 0 while ex_valid=0, including during the cycle after reset.
REQ-032 Reset asserted mid-stall SHALL discard the stalled state; after release, the first load comes from the current IF/ID inputs.

Structure
REQ-033 Package mips_pkg SHALL hold DATA_W, REG_AW, CTRL_W, ctrl bit indices, and FWD_NONE=00/FWD_WB=01/FWD_MEM=10.
REQ-034 The combinational compare logic (REQ-018..022) SHALL be one sub-module, hazard_fwd_unit; the pipeline register stays in id_ex_stage.

Verification
REQ-035 Load-use: EX holds lw with rt=8 and valid; ID has add rs=8, use_rs=1 -> stall=1, next ex_valid=0, stall_cnt 0->1, and the held add loads a cycle later with fwd_a=01.
REQ-036 EX forward: EX holds add with reg_write and dst=9; ID rs=9 -> next ex_fwd_a=10; if mem_rd=9 with mem_regwrite as well -> still 10.
REQ-037 WB bypass: wb_regwrite=1, wb_rd=5, wb_data=32'hDEADBEEF, id_rt=5, id_rd2=0 -> next ex_b=32'hDEADBEEF; with wb_rd=0 -> ex_b=0.
REQ-038 Flush and hazard together: conditions of REQ-035 plus flush=1 -> stall=0, bubble loaded, stall_cnt unchanged.
REQ-039 Saturation: preload stall_cnt to 16'hFFFE, run 3 stall cycles -> reads FFFF and holds.
REQ-040 Reset mid-stream: reset high for one edge during a stall -> all outputs 0 next cycle, stall=0.
